cb_shadow_config: RTL and testbench

- Next-generation connection block between two logic blocks and two routing-track directions.
- Routing selection is held in binary-encoded select registers, not SRL truth tables.
- Selects load serially into a shadow register and commit atomically on an UPDATE strobe, so routing never glitches mid-load.
- Adds load-length checking, an explicit "off" (drive 0) select, and an optional registered-output mode.

---
 rtl/cb_shadow_config.sv | 181 ++++++++++++++++++
 tb/tb_cb_shadow_config.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cb_shadow_config.sv
// Connection block with binary-encoded routing selects. Configuration is shifted
// into a shadow chain and committed atomically to the active selects on UPDATE.

module cb_lb_mux #(
  parameter int N    = 5,
  parameter int S_LB = 4
) (
  input  logic [S_LB-1:0] sel_i,
  input  logic [N-1:0]    cb1_i,
  input  logic [N-1:0]    cb2_i,
  output logic            out_o
);
  logic [2*N:0] cand;

  // Candidate 0 is the hard "off"; codes past 2N match nothing and also drive 0.
  assign cand = {cb2_i, cb1_i, 1'b0};

  always_comb begin
    out_o = 1'b0;
    for (int k = 1; k <= 2*N; k++)
      if (sel_i == S_LB'(k)) out_o = cand[k];
  end
endmodule

module cb_trk_mux #(
  parameter int P    = 1,
  parameter int S_CB = 2
) (
  input  logic [S_CB-1:0] sel_i,
  input  logic            cross_i,
  input  logic [P-1:0]    lb1_i,
  input  logic [P-1:0]    lb2_i,
  output logic            out_o
);
  logic [2*P+1:0] cand;

  assign cand = {lb2_i, lb1_i, cross_i, 1'b0};

  always_comb begin
    out_o = 1'b0;
    for (int k = 1; k <= 2*P+1; k++)
      if (sel_i == S_CB'(k)) out_o = cand[k];
  end
endmodule

module cb_shadow_config #(
  parameter int N       = 5,
  parameter int O       = 6,
  parameter int P       = 1,
  parameter int REG_OUT = 0
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         CE,
  input  logic         SIN,
  input  logic         UPDATE,
  input  logic [P-1:0] LB1_IN,
  input  logic [P-1:0] LB2_IN,
  input  logic [N-1:0] CB1_IN,
  input  logic [N-1:0] CB2_IN,
  output logic [O-1:0] LB1_OUT,
  output logic [O-1:0] LB2_OUT,
  output logic [N-1:0] CB1_OUT,
  output logic [N-1:0] CB2_OUT,
  output logic         SOUT,
  output logic         CFG_VALID,
  output logic         CFG_ERR
);
  localparam int S_LB     = $clog2(2*N+1);
  localparam int S_CB     = $clog2(2*P+2);
  localparam int CFG_BITS = 2*O*S_LB + 2*N*S_CB;
  localparam int CNT_W    = $clog2(CFG_BITS+2);
  localparam int LB2_OFF  = O*S_LB;
  localparam int CB1_OFF  = 2*O*S_LB;
  localparam int CB2_OFF  = CB1_OFF + N*S_CB;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_BITS);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CFG_BITS+1);

  logic [CFG_BITS-1:0] shadow_q, shadow_d;
  logic [CFG_BITS-1:0] active_q, active_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                cfg_full;

  assign cfg_full = (cnt_q == CNT_FULL);

  // UPDATE takes priority over CE: a shift coinciding with a commit is dropped.
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    if (UPDATE) begin
      cnt_d = '0;
      if (cfg_full) begin
        active_d = shadow_q;
        err_d    = 1'b0;
      end else begin
        err_d    = 1'b1;
      end
    end else if (CE) begin
      shadow_d = {SIN, shadow_q[CFG_BITS-1:1]};
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      shadow_q <= '0;
      active_q <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  assign SOUT      = shadow_q[0];
  assign CFG_VALID = cfg_full;
  assign CFG_ERR   = err_q;

  logic [O-1:0][S_LB-1:0] lb1_sel, lb2_sel;
  logic [N-1:0][S_CB-1:0] cb1_sel, cb2_sel;
  logic [O-1:0]           lb1_c, lb2_c;
  logic [N-1:0]           cb1_c, cb2_c;

  assign lb1_sel = active_q[LB2_OFF-1:0];
  assign lb2_sel = active_q[CB1_OFF-1:LB2_OFF];
  assign cb1_sel = active_q[CB2_OFF-1:CB1_OFF];
  assign cb2_sel = active_q[CFG_BITS-1:CB2_OFF];

  for (genvar j = 0; j < O; j++) begin : g_lb
    cb_lb_mux #(.N(N), .S_LB(S_LB)) u_lb1 (
      .sel_i(lb1_sel[j]), .cb1_i(CB1_IN), .cb2_i(CB2_IN), .out_o(lb1_c[j]));
    cb_lb_mux #(.N(N), .S_LB(S_LB)) u_lb2 (
      .sel_i(lb2_sel[j]), .cb1_i(CB1_IN), .cb2_i(CB2_IN), .out_o(lb2_c[j]));
  end

  // Each outgoing track may take the opposite-direction track of the same index.
  for (genvar i = 0; i < N; i++) begin : g_cb
    cb_trk_mux #(.P(P), .S_CB(S_CB)) u_cb1 (
      .sel_i(cb1_sel[i]), .cross_i(CB2_IN[i]), .lb1_i(LB1_IN), .lb2_i(LB2_IN),
      .out_o(cb1_c[i]));
    cb_trk_mux #(.P(P), .S_CB(S_CB)) u_cb2 (
      .sel_i(cb2_sel[i]), .cross_i(CB1_IN[i]), .lb1_i(LB1_IN), .lb2_i(LB2_IN),
      .out_o(cb2_c[i]));
  end

  if (REG_OUT != 0) begin : g_reg
    logic [O-1:0] lb1_q, lb2_q;
    logic [N-1:0] cb1_q, cb2_q;

    always_ff @(posedge CLK) begin
      if (RST) begin
        lb1_q <= '0;
        lb2_q <= '0;
        cb1_q <= '0;
        cb2_q <= '0;
      end else begin
        lb1_q <= lb1_c;
        lb2_q <= lb2_c;
        cb1_q <= cb1_c;
        cb2_q <= cb2_c;
      end
    end

    assign LB1_OUT = lb1_q;
    assign LB2_OUT = lb2_q;
    assign CB1_OUT = cb1_q;
    assign CB2_OUT = cb2_q;
  end else begin : g_comb
    assign LB1_OUT = lb1_c;
    assign LB2_OUT = lb2_c;
    assign CB1_OUT = cb1_c;
    assign CB2_OUT = cb2_c;
  end
endmodule

// File: tb/tb_cb_shadow_config.sv
// Bench for cb_shadow_config at defaults: a combinational and a registered-output
// instance share all stimulus; hand vectors plus a small routing model.

module tb_cb_shadow_config;
  localparam int NB = 68;
  localparam int L1 = 0, L2 = 24, C1 = 48, C2 = 58;

  logic       CLK = 1'b0;
  logic       RST, CE, SIN, UPDATE;
  logic [0:0] LB1_IN, LB2_IN;
  logic [4:0] CB1_IN, CB2_IN;
  logic [5:0] o_lb1, o_lb2, r_lb1, r_lb2;
  logic [4:0] o_cb1, o_cb2, r_cb1, r_cb2;
  logic       o_sout, o_vld, o_err, r_sout, r_vld, r_err;

  always #5 CLK = ~CLK;

  cb_shadow_config #(.N(5), .O(6), .P(1), .REG_OUT(0)) dut (
    .CLK(CLK), .RST(RST), .CE(CE), .SIN(SIN), .UPDATE(UPDATE),
    .LB1_IN(LB1_IN), .LB2_IN(LB2_IN), .CB1_IN(CB1_IN), .CB2_IN(CB2_IN),
    .LB1_OUT(o_lb1), .LB2_OUT(o_lb2), .CB1_OUT(o_cb1), .CB2_OUT(o_cb2),
    .SOUT(o_sout), .CFG_VALID(o_vld), .CFG_ERR(o_err));

  cb_shadow_config #(.N(5), .O(6), .P(1), .REG_OUT(1)) dutr (
    .CLK(CLK), .RST(RST), .CE(CE), .SIN(SIN), .UPDATE(UPDATE),
    .LB1_IN(LB1_IN), .LB2_IN(LB2_IN), .CB1_IN(CB1_IN), .CB2_IN(CB2_IN),
    .LB1_OUT(r_lb1), .LB2_OUT(r_lb2), .CB1_OUT(r_cb1), .CB2_OUT(r_cb2),
    .SOUT(r_sout), .CFG_VALID(r_vld), .CFG_ERR(r_err));

  typedef struct packed {
    logic [4:0] cb1;
    logic [4:0] cb2;
    logic       lb1;
    logic       lb2;
    logic [5:0] e_lb1;
    logic [5:0] e_lb2;
    logic [4:0] e_cb1;
    logic [4:0] e_cb2;
  } vec_t;

  vec_t tbl [7];

  int n_chk = 0;
  int n_fail = 0;

  logic [NB-1:0] mdl_shadow = '0;
  logic [NB-1:0] mdl_active = '0;
  int            mdl_cnt = 0;
  logic [21:0]   exp_reg;

  // Reference routing: index a candidate vector by the select, 0 when out of range.
  function automatic logic [21:0] model(input logic [NB-1:0] a, input logic [4:0] c1i,
                                        input logic [4:0] c2i, input logic l1i,
                                        input logic l2i);
    logic [10:0] lc;
    logic [3:0]  cc1, cc2;
    logic [3:0]  s;
    logic [1:0]  t;
    logic [5:0]  x1, x2;
    logic [4:0]  y1, y2;
    lc = {c2i, c1i, 1'b0};
    for (int j = 0; j < 6; j++) begin
      s = a[L1+4*j +: 4];
      x1[j] = (s <= 4'd10) ? lc[s] : 1'b0;
      s = a[L2+4*j +: 4];
      x2[j] = (s <= 4'd10) ? lc[s] : 1'b0;
    end
    for (int i = 0; i < 5; i++) begin
      cc1 = {l2i, l1i, c2i[i], 1'b0};
      cc2 = {l2i, l1i, c1i[i], 1'b0};
      t = a[C1+2*i +: 2];
      y1[i] = cc1[t];
      t = a[C2+2*i +: 2];
      y2[i] = cc2[t];
    end
    return {x1, x2, y1, y2};
  endfunction

  function automatic logic [NB-1:0] setf(input logic [NB-1:0] v, input int off,
                                          input int w, input int val);
    logic [NB-1:0] r;
    r = v;
    for (int b = 0; b < w; b++) r[off+b] = val[b];
    return r;
  endfunction

  always @(posedge CLK)
    if (RST) exp_reg <= '0;
    else     exp_reg <= model(mdl_active, CB1_IN, CB2_IN, LB1_IN[0], LB2_IN[0]);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_out(input string nm);
    logic [21:0] e;
    e = model(mdl_active, CB1_IN, CB2_IN, LB1_IN[0], LB2_IN[0]);
    chk({nm, " comb"}, 32'({o_lb1, o_lb2, o_cb1, o_cb2}), 32'(e));
    chk({nm, " reg"},  32'({r_lb1, r_lb2, r_cb1, r_cb2}), 32'(exp_reg));
  endtask

  task automatic step_bit(input logic b);
    CE = 1'b1; SIN = b;
    @(negedge CLK);
    CE = 1'b0;
    mdl_shadow = {b, mdl_shadow[NB-1:1]};
    if (mdl_cnt < NB+1) mdl_cnt++;
  endtask

  task automatic shift_n(input logic [NB-1:0] v, input int n);
    for (int i = 0; i < n; i++) step_bit(v[i % NB]);
  endtask

  task automatic commit(input logic ce_too);
    UPDATE = 1'b1; CE = ce_too; SIN = 1'b0;
    @(negedge CLK);
    UPDATE = 1'b0; CE = 1'b0;
    if (mdl_cnt == NB) mdl_active = mdl_shadow;
    mdl_cnt = 0;
  endtask

  task automatic set_in(input logic [4:0] c1, input logic [4:0] c2, input logic l1,
                        input logic l2);
    CB1_IN = c1; CB2_IN = c2; LB1_IN = l1; LB2_IN = l2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [NB-1:0] cfg_a, cfg_t, cfg_c, cfg_b;

    // Config C routes LB1[0]<-CB1_IN[0], LB2[5]<-CB2_IN[4], CB1[2]<-CB2_IN[2], CB2[0]<-LB2_IN[0].
    tbl[0] = {5'b00000, 5'b00000, 1'b0, 1'b0, 6'b000000, 6'b000000, 5'b00000, 5'b00000};
    tbl[1] = {5'b11111, 5'b11111, 1'b1, 1'b1, 6'b000001, 6'b100000, 5'b00100, 5'b00001};
    tbl[2] = {5'b00001, 5'b00000, 1'b0, 1'b0, 6'b000001, 6'b000000, 5'b00000, 5'b00000};
    tbl[3] = {5'b11110, 5'b10000, 1'b1, 1'b0, 6'b000000, 6'b100000, 5'b00000, 5'b00000};
    tbl[4] = {5'b00000, 5'b00100, 1'b0, 1'b1, 6'b000000, 6'b000000, 5'b00100, 5'b00001};
    tbl[5] = {5'b10101, 5'b01011, 1'b1, 1'b0, 6'b000001, 6'b000000, 5'b00000, 5'b00000};
    tbl[6] = {5'b01010, 5'b11111, 1'b0, 1'b1, 6'b000000, 6'b100000, 5'b00100, 5'b00001};

    cfg_a = setf(setf('0, L1+0, 4, 1), L2+20, 4, 10);
    cfg_t = setf(setf('0, C1+4, 2, 1), C2+0, 2, 3);
    cfg_c = setf(setf(cfg_a, C1+4, 2, 1), C2+0, 2, 3);
    cfg_b = '0;
    for (int j = 0; j < 5; j++) cfg_b = setf(cfg_b, L1+4*j, 4, 11+j);
    cfg_b = setf(cfg_b, L1+20, 4, 10);
    cfg_b = setf(cfg_b, L2+0, 4, 5);
    cfg_b = setf(cfg_b, L2+4, 4, 6);
    cfg_b = setf(cfg_b, C1+0, 2, 3);
    cfg_b = setf(cfg_b, C1+2, 2, 2);
    cfg_b = setf(cfg_b, C2+6, 2, 1);
    cfg_b = setf(cfg_b, C2+8, 2, 3);

    // Reset held with every control and data input high.
    RST = 1'b1; CE = 1'b1; UPDATE = 1'b1; SIN = 1'b1;
    set_in(5'h1f, 5'h1f, 1'b1, 1'b1);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst outs comb", 32'({o_lb1, o_lb2, o_cb1, o_cb2}), 32'd0);
    chk("rst outs reg",  32'({r_lb1, r_lb2, r_cb1, r_cb2}), 32'd0);
    chk("rst status",    32'({o_sout, o_vld, o_err}), 32'd0);
    chk("rst status reg", 32'({r_sout, r_vld, r_err}), 32'd0);
    RST = 1'b0; CE = 1'b0; UPDATE = 1'b0; SIN = 1'b0;

    // LB routing: nothing moves until the commit.
    shift_n(cfg_a, NB);
    chk("lbA valid", 32'(o_vld), 32'd1);
    chk("lbA pre-update lb1", 32'(o_lb1), 32'd0);
    chk("lbA pre-update lb2", 32'(o_lb2), 32'd0);
    commit(1'b0);
    chk("lbA err", 32'(o_err), 32'd0);
    chk("lbA valid cleared", 32'(o_vld), 32'd0);
    for (int t = 0; t < 4; t++) begin
      set_in(5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom));
      CB1_IN[0] = t[0];
      CB2_IN[4] = t[1];
      #1;
      chk("lbA lb1[0]", 32'(o_lb1[0]), 32'(t[0]));
      chk("lbA lb2[5]", 32'(o_lb2[5]), 32'(t[1]));
      check_out("lbA before edge");
      @(negedge CLK);
      check_out("lbA after edge");
    end

    // Registered instance lags the combinational one by exactly one edge.
    set_in(5'h00, 5'h00, 1'b0, 1'b0);
    @(negedge CLK);
    CB1_IN = 5'h01;
    #1;
    chk("lag comb new", 32'(o_lb1), 32'd1);
    chk("lag reg old",  32'(r_lb1), 32'd0);
    @(negedge CLK);
    chk("lag reg new",  32'(r_lb1), 32'd1);

    // Track routing.
    shift_n(cfg_t, NB);
    commit(1'b0);
    for (int k = 0; k < 6; k++) begin
      set_in(5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom));
      #1;
      chk("trk cb1[2]", 32'(o_cb1[2]), 32'(CB2_IN[2]));
      chk("trk cb2[0]", 32'(o_cb2[0]), 32'(LB2_IN[0]));
      chk("trk lb zero", 32'({o_lb1, o_lb2}), 32'd0);
      check_out("trk");
      @(negedge CLK);
    end

    // Combined config against hand-computed vectors.
    shift_n(cfg_c, NB);
    commit(1'b0);
    for (int v = 0; v < 7; v++) begin
      set_in(tbl[v].cb1, tbl[v].cb2, tbl[v].lb1, tbl[v].lb2);
      #1;
      chk($sformatf("tbl%0d comb", v), 32'({o_lb1, o_lb2, o_cb1, o_cb2}),
          32'({tbl[v].e_lb1, tbl[v].e_lb2, tbl[v].e_cb1, tbl[v].e_cb2}));
      @(negedge CLK);
      chk($sformatf("tbl%0d reg", v), 32'({r_lb1, r_lb2, r_cb1, r_cb2}),
          32'({tbl[v].e_lb1, tbl[v].e_lb2, tbl[v].e_cb1, tbl[v].e_cb2}));
    end

    // Length checking: short and long loads are refused and flagged.
    set_in(5'h1f, 5'h1f, 1'b1, 1'b1);
    shift_n(cfg_b, NB-1);
    chk("short valid", 32'(o_vld), 32'd0);
    commit(1'b0);
    chk("short err", 32'(o_err), 32'd1);
    chk("short outs kept", 32'({o_lb1, o_lb2, o_cb1, o_cb2}),
        32'({6'b000001, 6'b100000, 5'b00100, 5'b00001}));
    check_out("short");
    shift_n(cfg_b, NB);
    chk("long valid at 68", 32'(o_vld), 32'd1);
    step_bit(1'b0);
    chk("long valid at 69", 32'(o_vld), 32'd0);
    commit(1'b0);
    chk("long err", 32'(o_err), 32'd1);
    check_out("long");
    shift_n(cfg_b, NB);
    commit(1'b0);
    chk("good err clear", 32'(o_err), 32'd0);

    // Out-of-range LB selects and the extreme valid codes, all inputs high.
    #1;
    chk("bnd lb1", 32'(o_lb1), 32'b100000);
    chk("bnd lb2", 32'(o_lb2), 32'b000011);
    chk("bnd cb1", 32'(o_cb1), 32'b00011);
    chk("bnd cb2", 32'(o_cb2), 32'b11000);
    for (int k = 0; k < 4; k++) begin
      set_in(5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom));
      @(negedge CLK);
      check_out("bnd rand");
    end

    // CE with UPDATE: commit wins, shadow and count are not advanced by the shift.
    shift_n(cfg_a, NB);
    UPDATE = 1'b1; CE = 1'b1; SIN = 1'b0;
    @(negedge CLK);
    UPDATE = 1'b0; CE = 1'b0;
    mdl_active = mdl_shadow;
    mdl_cnt = 0;
    chk("ceupd valid", 32'(o_vld), 32'd0);
    chk("ceupd sout", 32'(o_sout), 32'd1);
    chk("ceupd err", 32'(o_err), 32'd0);
    check_out("ceupd");
    shift_n(cfg_c, NB-1);
    chk("ceupd cnt 67", 32'(o_vld), 32'd0);
    step_bit(cfg_c[NB-1]);
    chk("ceupd cnt 68", 32'(o_vld), 32'd1);
    commit(1'b0);

    // Readback: SOUT replays the committed pattern while routing stays put.
    for (int i = 0; i < NB; i++) begin
      if (i % 17 == 0) set_in(5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom));
      #1;
      chk($sformatf("rb sout%0d", i), 32'(o_sout), 32'(cfg_c[i]));
      if (i % 17 == 0) check_out("rb routing");
      step_bit(cfg_t[i]);
    end
    chk("rb valid", 32'(o_vld), 32'd1);
    check_out("rb end");

    // Reset mid-load clears the partial load and the sticky error.
    shift_n(cfg_b, 5);
    commit(1'b0);
    chk("mid err set", 32'(o_err), 32'd1);
    set_in(5'h1f, 5'h1f, 1'b1, 1'b1);
    shift_n(cfg_b, 20);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    mdl_active = '0; mdl_shadow = '0; mdl_cnt = 0;
    chk("mid outs", 32'({o_lb1, o_lb2, o_cb1, o_cb2}), 32'd0);
    chk("mid status", 32'({o_sout, o_vld, o_err}), 32'd0);
    check_out("mid");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
